// File: rtl/router_route_compute_pkg.sv
// Shared types and helpers for the per-input-port route stage: coordinate and
// VC types, start-flit field layout and the XY dimension-order route function.
package router_route_compute_pkg;

    localparam int COORD_BITS = 4;
    localparam int VC_BITS    = 2;
    localparam int FLIT_BITS  = 32;

    // Start-flit header layout: dest_x in the low nibble, dest_y above it, vc above that.
    localparam int DX_OFF = 0;
    localparam int DY_OFF = 4;
    localparam int VC_OFF = 8;

    typedef logic [COORD_BITS-1:0] coord_t;
    typedef logic [VC_BITS-1:0]    vc_t;
    typedef logic [FLIT_BITS-1:0]  flit_t;

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_EAST  = 3'd1,
        PORT_WEST  = 3'd2,
        PORT_NORTH = 3'd3,
        PORT_SOUTH = 3'd4
    } port_e;

    typedef struct packed {
        vc_t   vc;
        port_e port;
    } target_t;

    typedef struct packed {
        flit_t   flit;
        target_t target;
        logic    last;
    } entry_t;

    // True when the requested VC exists on the downstream ports.
    function automatic logic vc_in_range(vc_t vc, int unsigned vc_count);
        return (32'(vc) < vc_count);
    endfunction

    // X first, then Y; coordinates compared unsigned, no wrap-around.
    // An out-of-range VC is replaced by VC 0.
    function automatic target_t xy_route(coord_t dest_x, coord_t dest_y,
                                         coord_t my_x, coord_t my_y,
                                         vc_t vc, int unsigned vc_count);
        target_t t;
        t.vc = vc_in_range(vc, vc_count) ? vc : '0;
        if (dest_x > my_x)      t.port = PORT_EAST;
        else if (dest_x < my_x) t.port = PORT_WEST;
        else if (dest_y > my_y) t.port = PORT_NORTH;
        else if (dest_y < my_y) t.port = PORT_SOUTH;
        else                    t.port = PORT_LOCAL;
        return t;
    endfunction

endpackage

// File: rtl/router_skid_buffer.sv
// Generic 2-entry valid/ready elastic buffer. in_ready is a register so there
// is no combinational path from out_ready_i back to in_ready_o.
module router_skid_buffer #(
    parameter type DATA_T = logic
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid_i,
    output logic  in_ready_o,
    input  DATA_T in_data_i,
    output logic  out_valid_o,
    input  logic  out_ready_i,
    output DATA_T out_data_o
);

    logic [1:0] count_q, count_d;
    logic       ready_q;
    DATA_T      data0_q, data1_q;   // data0_q is always the head entry
    logic       push, pop;

    assign push = in_valid_i & ready_q;
    assign pop  = out_valid_o & out_ready_i;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 2'd1;
        else if (!push && pop)
            count_d = count_q - 2'd1;
    end

    // Control state; ready stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
        end
    end

    // Entry storage: shift on pop from full, write the incoming entry into the first free slot.
    always_ff @(posedge clk) begin
        if (pop && count_q == 2'd2)
            data0_q <= data1_q;
        if (push) begin
            if (count_q == 2'd0 || (count_q == 2'd1 && pop))
                data0_q <= in_data_i;
            else
                data1_q <= in_data_i;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = data0_q;

endmodule

// File: rtl/router_route_compute.sv
// Route stage for one router input: decodes the start flit with XY routing and
// tags every flit of the packet with the same {vc, port} target, so the
// crossbar sees a stable target from start flit to last flit.
// COORD_W must match COORD_BITS in the package.
module router_route_compute
    import router_route_compute_pkg::*;
#(
    parameter int          COORD_W  = 4,
    parameter int unsigned VC_COUNT = 2,
    parameter int          CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [31:0]        in_flit_i,
    input  logic               in_last_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [31:0]        out_flit_o,
    output logic [1:0]         out_vc_o,
    output logic [2:0]         out_port_o,
    output logic               out_last_o,
    input  logic [COORD_W-1:0] my_x_i,
    input  logic [COORD_W-1:0] my_y_i,
    output logic [CNT_W-1:0]   pkt_count_o,
    output logic               err_vc_o
);

    localparam logic [0:0] ST_HEAD = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    logic [0:0]       state_q, state_d;
    target_t          tgt_q;
    target_t          head_tgt, flit_tgt;
    logic             accept;
    logic             head_vc_bad;
    vc_t              head_vc;
    entry_t           push_entry, pop_entry;
    logic             err_vc_q;
    logic [CNT_W-1:0] pkt_count_q;

    assign accept      = in_valid_i & in_ready_o;
    assign head_vc     = in_flit_i[VC_OFF +: VC_BITS];
    assign head_vc_bad = ~vc_in_range(head_vc, VC_COUNT);
    assign head_tgt    = xy_route(in_flit_i[DX_OFF +: COORD_BITS], in_flit_i[DY_OFF +: COORD_BITS],
                                  my_x_i, my_y_i, head_vc, VC_COUNT);

    // A start flit uses the freshly computed target; body flits reuse the latched one.
    always_comb begin
        flit_tgt = (state_q == ST_HEAD) ? head_tgt : tgt_q;
        state_d  = state_q;
        if (accept)
            state_d = in_last_i ? ST_HEAD : ST_BODY;
    end

    assign push_entry = '{flit: in_flit_i, target: flit_tgt, last: in_last_i};

    // Packet state, sticky VC error and delivered-packet counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HEAD;
            err_vc_q    <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept && state_q == ST_HEAD && head_vc_bad)
                err_vc_q <= 1'b1;
            if (out_valid_o && out_ready_i && pop_entry.last)
                pkt_count_q <= pkt_count_q + CNT_W'(1);
        end
    end

    // Latch the target on each accepted start flit for the rest of the packet.
    always_ff @(posedge clk) begin
        if (accept && state_q == ST_HEAD)
            tgt_q <= head_tgt;
    end

    router_skid_buffer #(
        .DATA_T(entry_t)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (push_entry),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (pop_entry)
    );

    assign out_flit_o  = pop_entry.flit;
    assign out_vc_o    = pop_entry.target.vc;
    assign out_port_o  = pop_entry.target.port;
    assign out_last_o  = pop_entry.last;
    assign pkt_count_o = pkt_count_q;
    assign err_vc_o    = err_vc_q;

endmodule
